mux_nto1_rr: RTL and testbench

- Parametrised N-input, W-bit registered multiplexer; successor to the 2:1 combinational mux.
- Each input channel uses a valid/ready handshake. One registered output channel carries the data and its source channel index.
- Two modes:
  - static select, the classic mux behaviour driven by `sel`;
  - round-robin arbitration across all valid inputs.
- Sits between multiple producers and a single consumer in the datapath.

---
 rtl/mux_nto1_rr_pkg.sv | 10 +
 rtl/mux_nto1_rr_if.sv | 29 ++
 rtl/mux_nto1_rr_arbiter.sv | 52 +++++
 rtl/mux_nto1_rr.sv | 98 +++++++++
 tb/tb_mux_nto1_rr.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mux_nto1_rr_pkg.sv
// Shared defaults and mode encodings for the N:1 registered round-robin mux.
package mux_pkg;

    localparam int unsigned N_DEFAULT = 4;
    localparam int unsigned W_DEFAULT = 8;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Producer-side valid/ready bundle plus the registered consumer channel of mux_nto1_rr.
interface mux_nto1_rr_if
    import mux_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = W_DEFAULT
) ();

    localparam int unsigned SELW = $clog2(N);

    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mux_nto1_rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, and moves ptr past the winner on advance.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned N    = N_DEFAULT,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant_onehot,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;
    int unsigned     j;

    // First requester in the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_vld    = 1'b0;
        j            = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!grant_vld && req[SELW'(j)]) begin
                grant_vld                 = 1'b1;
                grant_idx                 = SELW'(j);
                grant_onehot[SELW'(j)]    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (advance && grant_vld) begin
            ptr_nxt = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-input registered mux with valid/ready per channel; static select or round-robin arbitration.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int unsigned N    = N_DEFAULT,
    parameter  int unsigned W    = W_DEFAULT,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    mux_nto1_rr_if.slave    bus
);

    logic            load_en;
    logic            transfer;
    logic            static_vld;
    logic [N-1:0]    static_onehot;
    logic            rr_vld;
    logic [N-1:0]    rr_onehot;
    logic [SELW-1:0] rr_idx;
    logic            grant_vld;
    logic [N-1:0]    grant_onehot;
    logic [SELW-1:0] grant;
    logic [W-1:0]    grant_data;

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [SELW-1:0] out_ch_q;

    assign load_en = !out_valid_q || bus.out_ready;

    // Static path: a sel with no matching channel (sel >= N) never grants.
    always_comb begin
        static_vld    = 1'b0;
        static_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i) && bus.in_valid[i]) begin
                static_vld       = 1'b1;
                static_onehot[i] = 1'b1;
            end
        end
    end

    rr_arbiter #(.N(N)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (bus.in_valid),
        .advance      ((mode == MODE_RR) && transfer),
        .grant_onehot (rr_onehot),
        .grant_idx    (rr_idx),
        .grant_vld    (rr_vld)
    );

    always_comb begin
        grant_vld    = static_vld;
        grant_onehot = static_onehot;
        grant        = sel;
        if (mode == MODE_RR) begin
            grant_vld    = rr_vld;
            grant_onehot = rr_onehot;
            grant        = rr_idx;
        end
    end

    assign transfer     = load_en && grant_vld;
    assign bus.in_ready = load_en ? grant_onehot : '0;

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    // Output register: load on transfer, otherwise drain when consumed; data/ch hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_ch_q    <= grant;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr (N=4, W=8): directed steps push expected beats, a monitor pops on consume.
module tb_mux_nto1_rr;
    import mux_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned SELW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode;
    logic [SELW-1:0] sel;

    mux_nto1_rr_if #(.N(N), .W(W)) bus ();

    mux_nto1_rr #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]    data;
        logic [SELW-1:0] ch;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; checks combinational ready and out_valid mid-cycle, queues the expected beat.
    task automatic step(input logic m, input logic [SELW-1:0] s, input logic [N-1:0] v,
                        input logic ordy, input logic [N-1:0] exp_rdy, input logic exp_ov,
                        input logic push, input logic [SELW-1:0] ech, input logic [W-1:0] edata);
        beat_t b;
        mode          = m;
        sel           = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        #3;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (push) begin
            b.data = edata;
            b.ch   = ech;
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: unexpected beat ch=%0d data=%0h at %0t",
                             bus.out_ch, bus.out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_ch", 32'(bus.out_ch), 32'(e.ch));
                end
            end
        end
    end

    localparam logic [N-1:0] ALL = 4'b1111;

    initial begin
        mode          = MODE_STATIC;
        sel           = '0;
        bus.in_valid  = '0;
        bus.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset out_ch", 32'(bus.out_ch), 32'd0);
        rst_n = 1'b1;

        // Static sweep
        step(MODE_STATIC, 2'd0, ALL, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hA0);
        step(MODE_STATIC, 2'd1, ALL, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        step(MODE_STATIC, 2'd2, ALL, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hC2);
        step(MODE_STATIC, 2'd3, ALL, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3);

        // Round-robin rotation, pointer untouched by static mode so it starts at 0
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA0);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hC2);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA0);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hC2);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3);

        // Sparse requests from ptr=0: channels 1 and 3 only
        step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3);
        step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3);

        // Backpressure with B1 held, ptr left at 2
        step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        step(MODE_RR, 2'd0, ALL, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
        step(MODE_RR, 2'd0, ALL, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
        step(MODE_RR, 2'd0, ALL, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hC2);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3);

        // Static select of a non-valid channel: pending beat drains, then idle
        step(MODE_STATIC, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
        step(MODE_STATIC, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
        step(MODE_STATIC, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);

        // Round-robin traffic, then async reset between edges
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hA0);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst out_data", 32'(bus.out_data), 32'd0);
        check("async rst out_ch", 32'(bus.out_ch), 32'd0);
        // The in-flight B1 beat is discarded by reset
        check("discarded beats", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arbitration restarts at channel 0
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hA0);
        step(MODE_RR, 2'd0, ALL, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hB1);

        // Drain
        step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
        step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
